confreg_responder: RTL and testbench
====================================

# confreg_responder

Responder on the CPU data-memory port: services the datapath's SRAM-style data requests (ce/we/sel/addr/wdata -> rdata). Decodes each request either to the data memory backend or to a small on-chip configuration-register file (LEDs, switches, timer/compare). Drives the CPU interrupt input from a timer-compare match. Sits between `datapath` and `data_mem` in the CPU top.

## Interface
Parameters:
- `CONF_BASE`, 16'hBFAF: `addr[31:16]` value selecting the register region.
- `LED_RST`, 16'h0000: reset value of the LED register.

Ports:
- `clk_i` in 1: clock. All state updates on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `ram_ce_i` in 1: request valid, from datapath.
- `ram_we_i` in 1: 1 = write, 0 = read.
- `ram_sel_i` in 4: byte-lane enables; bit n covers `wdata[8n+7:8n]`.
- `ram_addr_i` in 32: virtual byte address, word aligned.
- `ram_wdata_i` in 32: write data.
- `ram_data_o` out 32: read data, back to datapath.
- `mem_ce_o` out 1: backend enable.
- `mem_sel_o` out 4: backend byte write enables.
- `mem_addr_o` out 32: backend physical address.
- `mem_wdata_o` out 32: backend write data.
- `mem_rdata_i` in 32: backend read data, valid in the same CPU cycle; the backend is clocked on the inverted clock.
- `switch_i` in 16: board switches.
- `led_o` out 16: board LEDs, registered.
- `int_o` out 1: timer interrupt, to the CPU `int_i`.

## Operation
- Hit: `ram_ce_i && ram_addr_i[31:16] == CONF_BASE`. A hit never reaches the backend.
- On a miss:
  - `mem_ce_o = ram_ce_i`.
  - `mem_addr_o = {3'b000, ram_addr_i[28:0]}` (kseg0/kseg1 fold).
  - `mem_sel_o = ram_we_i ? ram_sel_i : 4'b0`.
  - `mem_wdata_o = ram_wdata_i`.
- On a hit, `mem_ce_o = 0` and `mem_sel_o = 0`.
- `ram_data_o` mux, selected by the current-cycle request:
  - miss: `mem_rdata_i`;
  - hit: register read value;
  - `ram_ce_i = 0`: 32'h0.
- Register offsets (`addr[15:0]`):
  - F000 LED, RW, bits [15:0]; upper bits read 0.
  - F004 SWITCH, RO, `{16'h0, switch_i}`.
  - E000 COUNT, RW. +1 every cycle; wraps FFFF_FFFF -> 0.
  - E004 COMPARE, RW. Any write clears pending.
  - E008 CTRL:
    - bit0 EN, RW.
    - bit1 PEND: reads the pending bit; writing 1 clears it (W1C).
    - Other bits read 0.
  - Unmapped offsets read 0; writes to them are ignored.
- Register writes are byte-lane masked by `ram_sel_i` and occur only when `ram_ce_i && ram_we_i`.
- Match: at the rising edge where `EN && COUNT_q == COMPARE_q`, PEND <= 1.
- `int_o = PEND & EN`, registered-state only. No combinational path from the request.
- Simultaneous events:
  - Software write to COUNT in the same cycle as the increment: the write wins and there is no increment that cycle.
  - Match set and clear (W1C on PEND, or a COMPARE write) in the same cycle: set wins.

## Timing
- Reads have zero added latency: `ram_data_o` is valid in the request cycle, so the datapath MEM stage completes in one cycle.
- Writes become visible on the next rising edge. A read of the same register in the following cycle returns the new value.
- COUNT reads return the pre-increment registered value.
- Reset values:
  - LED = `LED_RST`;
  - COUNT = 0;
  - COMPARE = FFFF_FFFF;
  - EN = 0;
  - PEND = 0;
  - `int_o` = 0;
  - `led_o` = `LED_RST`.
- `mem_*` and `ram_data_o` are combinational. They follow the inputs during reset.
- Reset asserted mid-operation clears all state at that edge. Any write presented in the same cycle is discarded.

## Configuration
- `CONFREG_TIMER_EN` defined: COUNT, COMPARE, CTRL and `int_o` are implemented as above.
- `CONFREG_TIMER_EN` undefined:
  - No timer flops.
  - E000/E004/E008 read 0 and ignore writes.
  - `int_o` is tied to 0.
  - LED and SWITCH are unchanged.

## Structure
- Package `confreg_pkg`:
  - `CONF_BASE` default;
  - offset localparams (`OFF_LED`, `OFF_SWITCH`, `OFF_COUNT`, `OFF_COMPARE`, `OFF_CTRL`);
  - CTRL bit indices;
  - COMPARE reset constant.
- Sub-module `confreg_timer`:
  - holds COUNT, COMPARE, EN and PEND;
  - handles write strobes and the match/set/clear priority;
  - is instantiated only under `CONFREG_TIMER_EN`.
- Top-level `confreg_responder` holds the decode, the read mux and the LED register.

## Test plan
- Miss routing: read at 0x9FC0_0010 -> `mem_ce_o = 1`, `mem_addr_o = 0x1FC0_0010`, `mem_sel_o = 0`, `ram_data_o = mem_rdata_i`. Write with sel=4'b0011 -> `mem_sel_o = 4'b0011`.
- LED byte lanes: write 0xBFAF_F000 data 0x1234_5678 sel=4'b0001 -> `led_o` = 0x0078 next cycle. A read of 0xBFAF_F000 returns 0x0000_0078. `mem_ce_o` stayed 0 throughout.
- Switch and unmapped: `switch_i = 0xA5A5`, read F004 -> 0x0000_A5A5. Read F100 -> 0. A write to F100 changes no register.
- Timer interrupt:
  - Set COMPARE = 10, write COUNT = 0, set EN = 1.
  - PEND rises at the edge where COUNT = 10; `int_o` = 1 the following cycle.
  - Write CTRL = 0x3 -> `int_o` = 0 next cycle.
- Priority and wrap: write COUNT = FFFF_FFFE and let it run -> reads FFFF_FFFF then 0. W1C of PEND in the same cycle as a match -> PEND stays 1.
- Reset mid-write: assert `rst_i` during a write of LED = 0xFFFF -> `led_o = LED_RST`, COUNT = 0, `int_o` = 0 after the edge. With the macro undefined, E000 reads 0 and `int_o` is constantly 0.

Source files
------------

// File: rtl/confreg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : confreg_pkg
// Description : Shared constants and helpers for the configuration-register
//               responder: region base, register offsets, CTRL bit indices,
//               reset constants and a byte-lane merge function.
// Revision    : 1.0 - initial release
// ============================================================================
package confreg_pkg;

    // Default value of addr[31:16] that selects the register region
    localparam logic [15:0] CONF_BASE_DEFAULT = 16'hBFAF;

    // Register offsets within the region (addr[15:0])
    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_SWITCH  = 16'hF004;
    localparam logic [15:0] OFF_COUNT   = 16'hE000;
    localparam logic [15:0] OFF_COMPARE = 16'hE004;
    localparam logic [15:0] OFF_CTRL    = 16'hE008;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_PEND_BIT = 1;

    // COMPARE comes out of reset at all-ones so a fresh COUNT cannot match early
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    // Replace the byte lanes of old_val selected by sel with those of new_val
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage : confreg_pkg
`default_nettype wire

// File: rtl/confreg_if.sv
`default_nettype none
// ============================================================================
// Module      : confreg_if
// Description : SRAM-style CPU data-memory request bus (ce/we/sel/addr/wdata
//               with same-cycle rdata). master = datapath, slave = responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface confreg_if;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output ce, we, sel, addr, wdata,
        input  rdata
    );

    modport slave (
        input  ce, we, sel, addr, wdata,
        output rdata
    );
endinterface : confreg_if
`default_nettype wire

// File: rtl/confreg_timer.sv
`default_nettype none
// ============================================================================
// Module      : confreg_timer
// Description : Free-running COUNT, COMPARE, CTRL.EN and CTRL.PEND with
//               byte-masked software writes. A software COUNT write replaces
//               the increment; a compare match setting PEND beats a
//               simultaneous clear. Instantiated only under CONFREG_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module confreg_timer
    import confreg_pkg::*;
(
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        wr_count_i,
    input  wire logic        wr_compare_i,
    input  wire logic        wr_ctrl_i,
    input  wire logic [3:0]  sel_i,
    input  wire logic [31:0] wdata_i,
    output logic      [31:0] count_o,
    output logic      [31:0] compare_o,
    output logic             en_o,
    output logic             pend_o,
    output logic             int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic        match;
    logic        pend_clr;

    // Next-state: write beats increment, match set beats any clear
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        en_d      = en_q;
        match     = en_q && (count_q == compare_q);
        pend_clr  = wr_compare_i ||
                    (wr_ctrl_i && sel_i[0] && wdata_i[CTRL_PEND_BIT]);

        if (wr_count_i)          count_d   = byte_merge(count_q, wdata_i, sel_i);
        if (wr_compare_i)        compare_d = byte_merge(compare_q, wdata_i, sel_i);
        if (wr_ctrl_i && sel_i[0]) en_d    = wdata_i[CTRL_EN_BIT];

        if (match)         pend_d = 1'b1;
        else if (pend_clr) pend_d = 1'b0;
        else               pend_d = pend_q;
    end

    // Timer state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= 32'd0;
            compare_q <= COMPARE_RST;
            en_q      <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign en_o      = en_q;
    assign pend_o    = pend_q;
    // Interrupt depends on flop state only, never on the current request
    assign int_o     = pend_q & en_q;

endmodule : confreg_timer
`default_nettype wire

// File: rtl/confreg_responder.sv
`default_nettype none
// ============================================================================
// Module      : confreg_responder
// Description : Responder on the CPU data-memory port. Decodes each request
//               to the data-memory backend (kseg0/kseg1 folded) or to the
//               on-chip register file (LED, SWITCH, optional timer), with a
//               zero-latency read mux. Build macro: CONFREG_TIMER_EN enables
//               COUNT/COMPARE/CTRL and the timer interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module confreg_responder
    import confreg_pkg::*;
#(
    parameter logic [15:0] CONF_BASE = CONF_BASE_DEFAULT,
    parameter logic [15:0] LED_RST   = 16'h0000
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    confreg_if.slave         ram,
    output logic             mem_ce_o,
    output logic      [3:0]  mem_sel_o,
    output logic      [31:0] mem_addr_o,
    output logic      [31:0] mem_wdata_o,
    input  wire logic [31:0] mem_rdata_i,
    input  wire logic [15:0] switch_i,
    output logic      [15:0] led_o,
    output logic             int_o
);

    logic        hit;
    logic [15:0] offset;
    logic        reg_wr;
    logic        wr_led;
    logic [15:0] led_q, led_d;
    logic [31:0] reg_rdata;

    assign hit    = ram.ce && (ram.addr[31:16] == CONF_BASE);
    assign offset = ram.addr[15:0];
    assign reg_wr = hit && ram.we;
    assign wr_led = reg_wr && (offset == OFF_LED);

    // Backend routing: hits are fenced off, misses pass through folded
    always_comb begin
        mem_ce_o    = ram.ce && !hit;
        mem_sel_o   = (ram.we && !hit) ? ram.sel : 4'b0000;
        mem_addr_o  = {3'b000, ram.addr[28:0]};
        mem_wdata_o = ram.wdata;
    end

`ifdef CONFREG_TIMER_EN
    logic [31:0] tmr_count;
    logic [31:0] tmr_compare;
    logic        tmr_en;
    logic        tmr_pend;

    confreg_timer u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_count_i   (reg_wr && (offset == OFF_COUNT)),
        .wr_compare_i (reg_wr && (offset == OFF_COMPARE)),
        .wr_ctrl_i    (reg_wr && (offset == OFF_CTRL)),
        .sel_i        (ram.sel),
        .wdata_i      (ram.wdata),
        .count_o      (tmr_count),
        .compare_o    (tmr_compare),
        .en_o         (tmr_en),
        .pend_o       (tmr_pend),
        .int_o        (int_o)
    );
`else
    assign int_o = 1'b0;
`endif

    // Register read value for the current offset; unmapped reads return 0
    always_comb begin
        reg_rdata = 32'h0;
        case (offset)
            OFF_LED:     reg_rdata = {16'h0, led_q};
            OFF_SWITCH:  reg_rdata = {16'h0, switch_i};
`ifdef CONFREG_TIMER_EN
            OFF_COUNT:   reg_rdata = tmr_count;
            OFF_COMPARE: reg_rdata = tmr_compare;
            OFF_CTRL:    reg_rdata = {30'h0, tmr_pend, tmr_en};
`endif
            default:     reg_rdata = 32'h0;
        endcase
    end

    // Read-data mux selected by the request in flight this cycle
    always_comb begin
        if (!ram.ce)  ram.rdata = 32'h0;
        else if (hit) ram.rdata = reg_rdata;
        else          ram.rdata = mem_rdata_i;
    end

    // LED next-state: only the two low byte lanes are backed by storage
    always_comb begin
        led_d = led_q;
        if (wr_led) begin
            if (ram.sel[0]) led_d[7:0]  = ram.wdata[7:0];
            if (ram.sel[1]) led_d[15:8] = ram.wdata[15:8];
        end
    end

    // LED register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) led_q <= LED_RST;
        else       led_q <= led_d;
    end

    assign led_o = led_q;

endmodule : confreg_responder
`default_nettype wire

// File: tb/tb_confreg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_confreg_responder
// Description : Directed self-checking bench for confreg_responder. Inputs
//               change on the falling edge; outputs are sampled away from
//               the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_confreg_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        intr;
    logic [31:0] rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    confreg_if bus ();

    confreg_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ram         (bus),
        .mem_ce_o    (mem_ce),
        .mem_sel_o   (mem_sel),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .switch_i    (sw),
        .led_o       (led),
        .int_o       (intr)
    );

    task automatic bus_idle();
        bus.ce    = 1'b0;
        bus.we    = 1'b0;
        bus.sel   = 4'b0000;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
    endtask

    // One write cycle: presented at a falling edge, committed at the next rise
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.sel = s;
        @(negedge clk);
        bus_idle();
    endtask

    // One read cycle: data sampled mid-cycle, before the rising edge
    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a; bus.sel = 4'b0000;
        #1;
        d = bus.rdata;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        mem_rdata = 32'h0;
        sw = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (led !== 16'h0000) begin n_bad++; $display("FAIL reset_led: got %h want 0000", led); end
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL reset_int: got %b want 0", intr); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL idle_rdata: got %h want 0", bus.rdata); end
        n_cmp++; if (mem_ce !== 1'b0) begin n_bad++; $display("FAIL idle_mem_ce: got %b want 0", mem_ce); end
        @(negedge clk);
    endtask

    task automatic test_miss();
        mem_rdata = 32'hDEAD_BEEF;
        bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h9FC0_0010; bus.sel = 4'b0000;
        #1;
        n_cmp++; if (mem_ce !== 1'b1) begin n_bad++; $display("FAIL miss_ce: got %b want 1", mem_ce); end
        n_cmp++; if (mem_addr !== 32'h1FC0_0010) begin n_bad++; $display("FAIL miss_addr: got %h want 1fc00010", mem_addr); end
        n_cmp++; if (mem_sel !== 4'b0000) begin n_bad++; $display("FAIL miss_rd_sel: got %b want 0000", mem_sel); end
        n_cmp++; if (bus.rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL miss_rdata: got %h want deadbeef", bus.rdata); end
        bus.we = 1'b1; bus.sel = 4'b0011; bus.wdata = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (mem_sel !== 4'b0011) begin n_bad++; $display("FAIL miss_wr_sel: got %b want 0011", mem_sel); end
        n_cmp++; if (mem_wdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL miss_wdata: got %h want cafef00d", mem_wdata); end
        @(negedge clk);
        bus_idle();
        #1;
        n_cmp++; if (mem_ce !== 1'b0) begin n_bad++; $display("FAIL miss_ce_off: got %b want 0", mem_ce); end
        @(negedge clk);
    endtask

    task automatic test_led();
        bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'hBFAF_F000;
        bus.wdata = 32'h1234_5678; bus.sel = 4'b0001;
        #1;
        n_cmp++; if (mem_ce !== 1'b0) begin n_bad++; $display("FAIL led_mem_ce: got %b want 0", mem_ce); end
        n_cmp++; if (mem_sel !== 4'b0000) begin n_bad++; $display("FAIL led_mem_sel: got %b want 0000", mem_sel); end
        @(negedge clk);
        bus_idle();
        n_cmp++; if (led !== 16'h0078) begin n_bad++; $display("FAIL led_lane0: got %h want 0078", led); end
        bus_rd(32'hBFAF_F000, rd);
        n_cmp++; if (rd !== 32'h0000_0078) begin n_bad++; $display("FAIL led_read: got %h want 00000078", rd); end
        bus_wr(32'hBFAF_F000, 32'hFFFF_AB00, 4'b0010);
        n_cmp++; if (led !== 16'hAB78) begin n_bad++; $display("FAIL led_lane1: got %h want ab78", led); end
    endtask

    task automatic test_switch_unmapped();
        sw = 16'hA5A5;
        bus_rd(32'hBFAF_F004, rd);
        n_cmp++; if (rd !== 32'h0000_A5A5) begin n_bad++; $display("FAIL switch_read: got %h want 0000a5a5", rd); end
        bus_rd(32'hBFAF_F100, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", rd); end
        bus_wr(32'hBFAF_F100, 32'hFFFF_FFFF, 4'b1111);
        n_cmp++; if (led !== 16'hAB78) begin n_bad++; $display("FAIL unmapped_wr_led: got %h want ab78", led); end
        bus_rd(32'hBFAF_F000, rd);
        n_cmp++; if (rd !== 32'h0000_AB78) begin n_bad++; $display("FAIL unmapped_wr_read: got %h want 0000ab78", rd); end
    endtask

`ifdef CONFREG_TIMER_EN
    task automatic test_timer_irq();
        bus_wr(32'hBFAF_E004, 32'd10, 4'b1111);
        bus_wr(32'hBFAF_E000, 32'd0, 4'b1111);
        bus_wr(32'hBFAF_E008, 32'h1, 4'b0001);
        // COUNT now 1; nine more edges bring it to 10 without a match yet
        repeat (9) @(negedge clk);
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", intr); end
        @(negedge clk);
        n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL irq_match: got %b want 1", intr); end
        bus_rd(32'hBFAF_E008, rd);
        n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL ctrl_read: got %h want 3", rd); end
        bus_wr(32'hBFAF_E008, 32'h3, 4'b0001);
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL irq_w1c: got %b want 0", intr); end
        bus_rd(32'hBFAF_E008, rd);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL ctrl_after_w1c: got %h want 1", rd); end
    endtask

    task automatic test_priority_wrap();
        bus_wr(32'hBFAF_E004, 32'd102, 4'b1111);
        bus_wr(32'hBFAF_E000, 32'd100, 4'b1111);
        repeat (2) @(negedge clk);
        // COUNT is 102 here: the match edge coincides with the W1C
        bus_wr(32'hBFAF_E008, 32'h3, 4'b0001);
        n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL set_beats_w1c: got %b want 1", intr); end
        bus_wr(32'hBFAF_E004, 32'hFFFF_FFFF, 4'b1111);
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL compare_wr_clr: got %b want 0", intr); end
        bus_wr(32'hBFAF_E000, 32'hFFFF_FFFE, 4'b1111);
        bus_rd(32'hBFAF_E000, rd);
        n_cmp++; if (rd !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL wrap_0: got %h want fffffffe", rd); end
        bus_rd(32'hBFAF_E000, rd);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_1: got %h want ffffffff", rd); end
        bus_rd(32'hBFAF_E000, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wrap_2: got %h want 0", rd); end
        n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL wrap_match: got %b want 1", intr); end
    endtask
`else
    task automatic test_timer_disabled();
        bus_wr(32'hBFAF_E008, 32'h3, 4'b1111);
        bus_wr(32'hBFAF_E004, 32'h0, 4'b1111);
        bus_wr(32'hBFAF_E000, 32'h5, 4'b1111);
        repeat (3) @(negedge clk);
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL notmr_int: got %b want 0", intr); end
        bus_rd(32'hBFAF_E000, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL notmr_count: got %h want 0", rd); end
        bus_rd(32'hBFAF_E004, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL notmr_compare: got %h want 0", rd); end
        bus_rd(32'hBFAF_E008, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL notmr_ctrl: got %h want 0", rd); end
    endtask
`endif

    task automatic test_reset_mid_write();
        bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'hBFAF_F000;
        bus.wdata = 32'h0000_FFFF; bus.sel = 4'b1111;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_idle();
        n_cmp++; if (led !== 16'h0000) begin n_bad++; $display("FAIL rstw_led: got %h want 0000", led); end
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL rstw_int: got %b want 0", intr); end
        bus_rd(32'hBFAF_E000, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rstw_count: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_led();
        test_switch_unmapped();
`ifdef CONFREG_TIMER_EN
        test_timer_irq();
        test_priority_wrap();
`else
        test_timer_disabled();
`endif
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_confreg_responder
`default_nettype wire
